// File: rtl/ram_cmd_arbiter.sv
// Round-robin arbiter that turns whole read/write transactions from two requesters
// into the RAM's two-beat command protocol and routes the response back to the owner.
module ram_cmd_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int TIMEOUT    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              req_valid,
  output logic [1:0]              req_ready,
  input  logic [1:0]              req_wr,
  input  logic [2*ADDR_WIDTH-1:0] req_addr,
  input  logic [2*ADDR_WIDTH-1:0] req_wdata,
  output logic [1:0]              rsp_valid,
  output logic [ADDR_WIDTH-1:0]   rsp_data,
  output logic                    rsp_err,
  output logic [ADDR_WIDTH+1:0]   ram_din,
  output logic                    ram_rx_valid,
  input  logic [ADDR_WIDTH-1:0]   ram_dout,
  input  logic                    ram_tx_valid
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [1:0] S_WAIT = 2'd3;

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [1:0]            state;
  logic                  last_grant;
  logic                  owner;
  logic                  wr;
  logic [ADDR_WIDTH-1:0] wdata;
  logic [CNT_W-1:0]      cnt;

  logic                  grant_any;
  logic                  grant_sel;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [ADDR_WIDTH-1:0] sel_wdata;

  // Grant is masked during reset so no handshake can be lost to the reset edge.
  always_comb begin
    grant_any = 1'b0;
    grant_sel = 1'b0;
    req_ready = 2'b00;
    if (state == S_IDLE && !rst) begin
      case (req_valid)
        2'b01:   begin grant_any = 1'b1; grant_sel = 1'b0;        end
        2'b10:   begin grant_any = 1'b1; grant_sel = 1'b1;        end
        2'b11:   begin grant_any = 1'b1; grant_sel = ~last_grant; end
        default: begin grant_any = 1'b0; grant_sel = 1'b0;        end
      endcase
      if (grant_any) begin
        req_ready = grant_sel ? 2'b10 : 2'b01;
      end
    end
  end

  assign sel_addr  = grant_sel ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]  : req_addr[ADDR_WIDTH-1:0];
  assign sel_wdata = grant_sel ? req_wdata[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_wdata[ADDR_WIDTH-1:0];

  // The address beat is registered on the accept edge, so only wr/wdata/owner need latching.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      last_grant   <= 1'b1;
      owner        <= 1'b0;
      wr           <= 1'b0;
      wdata        <= '0;
      cnt          <= '0;
      rsp_valid    <= 2'b00;
      rsp_data     <= '0;
      rsp_err      <= 1'b0;
      ram_din      <= '0;
      ram_rx_valid <= 1'b0;
    end else begin
      rsp_valid    <= 2'b00;
      rsp_data     <= '0;
      rsp_err      <= 1'b0;
      ram_din      <= '0;
      ram_rx_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (grant_any) begin
            owner        <= grant_sel;
            last_grant   <= grant_sel;
            wr           <= req_wr[grant_sel];
            wdata        <= sel_wdata;
            ram_rx_valid <= 1'b1;
            ram_din      <= {(req_wr[grant_sel] ? 2'b00 : 2'b10), sel_addr};
            state        <= S_ADDR;
          end
        end
        S_ADDR: begin
          ram_rx_valid <= 1'b1;
          ram_din      <= wr ? {2'b01, wdata} : {2'b11, {ADDR_WIDTH{1'b0}}};
          state        <= S_DATA;
        end
        S_DATA: begin
          if (wr) begin
            rsp_valid <= owner ? 2'b10 : 2'b01;
            state     <= S_IDLE;
          end else begin
            cnt   <= '0;
            state <= S_WAIT;
          end
        end
        default: begin
          // Data on the final timeout cycle still wins over the error.
          if (ram_tx_valid) begin
            rsp_valid <= owner ? 2'b10 : 2'b01;
            rsp_data  <= ram_dout;
            state     <= S_IDLE;
          end else if (cnt == CNT_LAST) begin
            rsp_valid <= owner ? 2'b10 : 2'b01;
            rsp_err   <= 1'b1;
            state     <= S_IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_cmd_arbiter.sv
// Directed bench for ram_cmd_arbiter: a per-cycle vector table plus a
// hand-written round-robin contention sequence with a one-cycle RAM reply.
module tb_ram_cmd_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [1:0]  req_wr;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic [1:0]  rsp_valid;
  logic [7:0]  rsp_data;
  logic        rsp_err;
  logic [9:0]  ram_din;
  logic        ram_rx_valid;
  logic [7:0]  ram_dout;
  logic        ram_tx_valid;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ram_cmd_arbiter #(.ADDR_WIDTH(8), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .ram_din(ram_din), .ram_rx_valid(ram_rx_valid),
    .ram_dout(ram_dout), .ram_tx_valid(ram_tx_valid)
  );

  typedef struct {
    logic        rst;
    logic [1:0]  rv;
    logic [1:0]  wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        tx;
    logic [7:0]  dout;
    logic [1:0]  e_ready;
    logic [1:0]  e_rsp_valid;
    logic [7:0]  e_rsp_data;
    logic        e_err;
    logic [9:0]  e_din;
    logic        e_rx;
  } vec_t;

  vec_t vecs [0:36];

  task automatic applyStimulus(input logic r, input logic [1:0] rv, input logic [1:0] wr,
                               input logic [15:0] addr, input logic [15:0] wdata,
                               input logic tx, input logic [7:0] dout);
    rst          = r;
    req_valid    = rv;
    req_wr       = wr;
    req_addr     = addr;
    req_wdata    = wdata;
    ram_tx_valid = tx;
    ram_dout     = dout;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // rst rv wr addr wdata tx dout | ready rsp_valid rsp_data err din rx
    vecs[0]  = '{1'b1, 2'b00, 2'b00, 16'h0000, 16'h0000, 1'b0, 8'h00, 2'b00, 2'b00, 8'h00, 1'b0, 10'h000, 1'b0};
    vecs[1]  = '{1'b0, 2'b01, 2'b01, 16'h003C, 16'h00A5, 1'b0, 8'h00, 2'b01, 2'b00, 8'h00, 1'b0, 10'h000, 1'b0};
    vecs[2]  = '{1'b0, 2'b00, 2'b00, 16'h0000, 16'h0000, 1'b0, 8'h00, 2'b00, 2'b00, 8'h00, 1'b0, 10'h03C, 1'b1};
    vecs[3]  = '{1'b0, 2'b00, 2'b00, 16'h0000, 16'h0000, 1'b0, 8'h00, 2'b00, 2'b00, 8'h00, 1'b0, 10'h1A5, 1'b1};
    vecs[4]  = '{1'b0, 2'b00, 2'b00, 16'h0000, 16'h0000, 1'b0, 8'h00, 2'b00, 2'b01, 8'h00, 1'b0, 10'h000, 1'b0};
    vecs[5]  = '{1'b0, 2'b10, 2'b00, 16'h3C00, 16'h0000, 1'b0, 8'h00, 2'b10, 2'b00, 8'h00, 1'b0, 10'h000, 1'b0};
    vecs[6]  = '{1'b0, 2'b00, 2'b00, 16'h0000, 16'h0000, 1'b0, 8'h00, 2'b00, 2'b00, 8'h00, 1'b0, 10'h23C, 1'b1};
    vecs[7]  = '{1'b0, 2'b00, 2'b00, 16'h0000, 16'h0000, 1'b0, 8'h00, 2'b00, 2'b00, 8'h00, 1'b0, 10'h300, 1'b1};
    vecs[8]  = '{1'b0, 2'b00, 2'b00, 16'h0000, 16'h0000, 1'b1, 8'hA5, 2'b00, 2'b00, 8'h00, 1'b0, 10'h000, 1'b0};
    vecs[9]  = '{1'b0, 2'b00, 2'b00, 16'h0000, 16'h0000, 1'b0, 8'h00, 2'b00, 2'b10, 8'hA5, 1'b0, 10'h000, 1'b0};
    vecs[10] = '{1'b0, 2'b00, 2'b00, 16'h0000, 16'h0000, 1'b1, 8'h55, 2'b00, 2'b00, 8'h00, 1'b0, 10'h000, 1'b0};
    vecs[11] = '{1'b0, 2'b00, 2'b00, 16'h0000, 16'h0000, 1'b0, 8'h00, 2'b00, 2'b00, 8'h00, 1'b0, 10'h000, 1'b0};
    vecs[12] = '{1'b0, 2'b01, 2'b00, 16'h0012, 16'h0000, 1'b0, 8'h00, 2'b01, 2'b00, 8'h00, 1'b0, 10'h000, 1'b0};
    vecs[13] = '{1'b0, 2'b00, 2'b00, 16'h0000, 16'h0000, 1'b0, 8'h00, 2'b00, 2'b00, 8'h00, 1'b0, 10'h212, 1'b1};
    vecs[14] = '{1'b0, 2'b00, 2'b00, 16'h0000, 16'h0000, 1'b0, 8'h00, 2'b00, 2'b00, 8'h00, 1'b0, 10'h300, 1'b1};
    vecs[15] = '{1'b0, 2'b00, 2'b00, 16'h0000, 16'h0000, 1'b0, 8'h00, 2'b00, 2'b00, 8'h00, 1'b0, 10'h000, 1'b0};
    vecs[16] = '{1'b0, 2'b00, 2'b00, 16'h0000, 16'h0000, 1'b0, 8'h00, 2'b00, 2'b00, 8'h00, 1'b0, 10'h000, 1'b0};
    vecs[17] = '{1'b0, 2'b00, 2'b00, 16'h0000, 16'h0000, 1'b0, 8'h00, 2'b00, 2'b00, 8'h00, 1'b0, 10'h000, 1'b0};
    vecs[18] = '{1'b0, 2'b00, 2'b00, 16'h0000, 16'h0000, 1'b0, 8'h00, 2'b00, 2'b00, 8'h00, 1'b0, 10'h000, 1'b0};
    vecs[19] = '{1'b0, 2'b10, 2'b10, 16'h4400, 16'h6600, 1'b0, 8'h00, 2'b10, 2'b01, 8'h00, 1'b1, 10'h000, 1'b0};
    vecs[20] = '{1'b0, 2'b00, 2'b00, 16'h0000, 16'h0000, 1'b0, 8'h00, 2'b00, 2'b00, 8'h00, 1'b0, 10'h044, 1'b1};
    vecs[21] = '{1'b0, 2'b00, 2'b00, 16'h0000, 16'h0000, 1'b0, 8'h00, 2'b00, 2'b00, 8'h00, 1'b0, 10'h166, 1'b1};
    vecs[22] = '{1'b0, 2'b00, 2'b00, 16'h0000, 16'h0000, 1'b0, 8'h00, 2'b00, 2'b10, 8'h00, 1'b0, 10'h000, 1'b0};
    vecs[23] = '{1'b0, 2'b01, 2'b00, 16'h0007, 16'h0000, 1'b0, 8'h00, 2'b01, 2'b00, 8'h00, 1'b0, 10'h000, 1'b0};
    vecs[24] = '{1'b0, 2'b00, 2'b00, 16'h0000, 16'h0000, 1'b0, 8'h00, 2'b00, 2'b00, 8'h00, 1'b0, 10'h207, 1'b1};
    vecs[25] = '{1'b0, 2'b00, 2'b00, 16'h0000, 16'h0000, 1'b0, 8'h00, 2'b00, 2'b00, 8'h00, 1'b0, 10'h300, 1'b1};
    vecs[26] = '{1'b0, 2'b00, 2'b00, 16'h0000, 16'h0000, 1'b0, 8'h00, 2'b00, 2'b00, 8'h00, 1'b0, 10'h000, 1'b0};
    vecs[27] = '{1'b0, 2'b00, 2'b00, 16'h0000, 16'h0000, 1'b0, 8'h00, 2'b00, 2'b00, 8'h00, 1'b0, 10'h000, 1'b0};
    vecs[28] = '{1'b0, 2'b00, 2'b00, 16'h0000, 16'h0000, 1'b0, 8'h00, 2'b00, 2'b00, 8'h00, 1'b0, 10'h000, 1'b0};
    vecs[29] = '{1'b0, 2'b00, 2'b00, 16'h0000, 16'h0000, 1'b1, 8'h5A, 2'b00, 2'b00, 8'h00, 1'b0, 10'h000, 1'b0};
    vecs[30] = '{1'b0, 2'b00, 2'b00, 16'h0000, 16'h0000, 1'b0, 8'h00, 2'b00, 2'b01, 8'h5A, 1'b0, 10'h000, 1'b0};
    vecs[31] = '{1'b0, 2'b01, 2'b00, 16'h0008, 16'h0000, 1'b0, 8'h00, 2'b01, 2'b00, 8'h00, 1'b0, 10'h000, 1'b0};
    vecs[32] = '{1'b0, 2'b00, 2'b00, 16'h0000, 16'h0000, 1'b0, 8'h00, 2'b00, 2'b00, 8'h00, 1'b0, 10'h208, 1'b1};
    vecs[33] = '{1'b0, 2'b00, 2'b00, 16'h0000, 16'h0000, 1'b0, 8'h00, 2'b00, 2'b00, 8'h00, 1'b0, 10'h300, 1'b1};
    vecs[34] = '{1'b1, 2'b11, 2'b00, 16'h2010, 16'h0000, 1'b0, 8'h00, 2'b00, 2'b00, 8'h00, 1'b0, 10'h000, 1'b0};
    vecs[35] = '{1'b0, 2'b11, 2'b00, 16'h2010, 16'h0000, 1'b0, 8'h00, 2'b01, 2'b00, 8'h00, 1'b0, 10'h000, 1'b0};
    vecs[36] = '{1'b0, 2'b00, 2'b00, 16'h0000, 16'h0000, 1'b0, 8'h00, 2'b00, 2'b00, 8'h00, 1'b0, 10'h210, 1'b1};

    applyStimulus(1'b1, 2'b00, 2'b00, 16'h0, 16'h0, 1'b0, 8'h0);
    nextCycle();
    nextCycle();

    for (int k = 0; k <= 36; k++) begin
      applyStimulus(vecs[k].rst, vecs[k].rv, vecs[k].wr, vecs[k].addr, vecs[k].wdata,
                    vecs[k].tx, vecs[k].dout);
      #1;
      checkOutput($sformatf("v%0d req_ready", k), 32'(req_ready), 32'(vecs[k].e_ready));
      checkOutput($sformatf("v%0d rsp_valid", k), 32'(rsp_valid), 32'(vecs[k].e_rsp_valid));
      checkOutput($sformatf("v%0d rsp_data", k), 32'(rsp_data), 32'(vecs[k].e_rsp_data));
      checkOutput($sformatf("v%0d rsp_err", k), 32'(rsp_err), 32'(vecs[k].e_err));
      checkOutput($sformatf("v%0d ram_din", k), 32'(ram_din), 32'(vecs[k].e_din));
      checkOutput($sformatf("v%0d ram_rx_valid", k), 32'(ram_rx_valid), 32'(vecs[k].e_rx));
      nextCycle();
    end

    // Contention: both requesters read continuously; RAM answers one cycle after each trigger.
    applyStimulus(1'b1, 2'b11, 2'b00, 16'h2010, 16'h0, 1'b0, 8'h0);
    nextCycle();
    for (int i = 0; i < 4; i++) begin
      logic owner;
      logic prev;
      owner = i[0];
      prev  = ~owner;
      applyStimulus(1'b0, 2'b11, 2'b00, 16'h2010, 16'h0, 1'b0, 8'h0);
      #1;
      checkOutput($sformatf("rr%0d grant", i), 32'(req_ready), owner ? 32'h2 : 32'h1);
      if (i > 0) begin
        checkOutput($sformatf("rr%0d rsp_valid", i), 32'(rsp_valid), prev ? 32'h2 : 32'h1);
        checkOutput($sformatf("rr%0d rsp_data", i), 32'(rsp_data), prev ? 32'hB1 : 32'hA0);
      end
      nextCycle();
      checkOutput($sformatf("rr%0d addr beat", i), 32'(ram_din), owner ? 32'h220 : 32'h210);
      nextCycle();
      checkOutput($sformatf("rr%0d trigger beat", i), 32'(ram_din), 32'h300);
      nextCycle();
      applyStimulus(1'b0, 2'b11, 2'b00, 16'h2010, 16'h0, 1'b1, owner ? 8'hB1 : 8'hA0);
      #1;
      checkOutput($sformatf("rr%0d quiet wait", i), 32'({rsp_valid, ram_rx_valid}), 32'h0);
      nextCycle();
    end
    applyStimulus(1'b0, 2'b00, 2'b00, 16'h0, 16'h0, 1'b0, 8'h0);
    #1;
    checkOutput("rr last rsp_valid", 32'(rsp_valid), 32'h2);
    checkOutput("rr last rsp_data", 32'(rsp_data), 32'hB1);
    checkOutput("rr last rsp_err", 32'(rsp_err), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
